sseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It shares one hex-to-segment decoder across `NUM_DIGITS` digits by cycling the digit anodes. A blanking interval between digits suppresses ghosting. New display values are double-buffered and committed only at frame boundaries, so a frame never tears. It sits between the design's status/counter logic and the board's anode and segment pins.

---
 rtl/sseg_pkg.sv | 23 ++
 rtl/sseg_scan_ctrl_hex2sseg.sv | 36 +++
 rtl/sseg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types, constants and the leading-zero enable rule for the seven-segment scan controller.
package sseg_pkg;

  typedef enum logic {S_BLANK, S_SHOW} scan_state_t;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  localparam int         MAX_DIGITS = 16;
  localparam int         SEL_W      = $clog2(MAX_DIGITS);

  // A digit is lit when enabled, unless it is a zero with only zeros above it (digit 0 always shows).
  function automatic logic digit_enabled(input logic [4*MAX_DIGITS-1:0] value,
                                         input logic [MAX_DIGITS-1:0]   en,
                                         input logic                    lz,
                                         input logic [SEL_W-1:0]        sel);
    logic above_zero;
    above_zero = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((SEL_W'(i) > sel) && (value[4*i +: 4] != 4'h0)) above_zero = 1'b0;
    end
    return en[sel] && !(lz && (sel != '0) && above_zero && (value[{sel, 2'b00} +: 4] == 4'h0));
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_hex2sseg.sv
// Shared hex-to-segment decoder; active-low {g..a}, fully blank when not enabled.
module hex2sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       en,
  output logic [6:0] seg
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    seg = SSEG_BLANK;
    if (en) begin
      case (nibble)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
        default: seg = SSEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: blank/show per digit, frame-boundary commit of double-buffered data.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    frame_done,
  output logic                    load_ack
);

  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t       state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              frame_end_nx;

  logic [4*NUM_DIGITS-1:0] act_val, pend_val;
  logic [NUM_DIGITS-1:0]   act_en, pend_en;
  logic                    act_lz, pend_lz, pend_valid;

  logic [4*MAX_DIGITS-1:0] val_ext;
  logic [MAX_DIGITS-1:0]   en_ext;
  logic                    cur_en;
  logic [6:0]              dec_seg;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    case (state)
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
        end
      end
      S_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nx = S_BLANK;
        cnt_nx   = '0;
      end
    endcase
  end

  // The register update that enters the last SHOW cycle of the last digit raises frame_done.
  assign frame_end_nx = (state_nx == S_SHOW) && (cnt_nx == SHOW_LAST) && (idx == IDX_LAST);

  always_comb begin
    val_ext                   = '0;
    en_ext                    = '0;
    val_ext[4*NUM_DIGITS-1:0] = act_val;
    en_ext[NUM_DIGITS-1:0]    = act_en;
    cur_en                    = digit_enabled(val_ext, en_ext, act_lz, SEL_W'(idx));
  end

  hex2sseg u_dec (
    .nibble (act_val[{idx, 2'b00} +: 4]),
    .en     (cur_en),
    .seg    (dec_seg)
  );

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BLANK;
      idx        <= '0;
      cnt        <= '0;
      an         <= '1;
      sseg       <= SSEG_BLANK;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      an         <= '1;
      sseg       <= SSEG_BLANK;
      if (state_nx == S_SHOW) begin
        an   <= ~(NUM_DIGITS'(1) << idx);
        sseg <= dec_seg;
      end
      frame_done <= frame_end_nx;
      load_ack   <= frame_end_nx && (pend_valid || load);
    end
  end

  // Commit happens on the edge that closes the frame_done cycle; a load on that same edge stays pending.
  // NOTE: the data buffers are reset too, because a reset must leave the display dark and discard queued data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val    <= '0;
      act_en     <= '0;
      act_lz     <= 1'b0;
      pend_val   <= '0;
      pend_en    <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
    end else begin
      if (load_ack) begin
        act_val <= pend_val;
        act_en  <= pend_en;
        act_lz  <= pend_lz;
      end
      if (load) begin
        pend_val   <= value;
        pend_en    <= digit_en;
        pend_lz    <= lz_suppress;
        pend_valid <= 1'b1;
      end else if (load_ack) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: frame-position reference model, table vectors, corner sequences, random loads.
module tb_sseg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIVP  = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = BLK + DIVP;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        frame_done, load_ack;

  sseg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIVP), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .an(an), .sseg(sseg), .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time since reset plus active/pending buffers.
  int          t;
  logic [15:0] a_val, p_val;
  logic [3:0]  a_en, p_en;
  logic        a_lz, p_lz, pv;

  int          off_run, first_lit, ack_seen, seg_lit;
  logic [3:0]  last_lit;
  int          fd_q[$];

  bit              tbl_on = 1'b0;
  logic [3:0][6:0] tbl_seg;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      en;
    logic            lz;
    logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; a_val = '0; a_en = '0; a_lz = 1'b0;
    p_val = '0; p_en = '0; p_lz = 1'b0; pv = 1'b0;
    off_run = 0; last_lit = 4'hF; first_lit = -1;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] e, input logic lz);
    int pos, d, w, hi;
    logic [3:0] ea;
    logic [6:0] es;
    logic ef, ek;
    @(negedge clk);
    load = ld; value = v; digit_en = e; lz_suppress = lz;
    pos = t % FRAME; d = pos / SLOT; w = pos % SLOT;
    hi = -1;
    for (int i = 0; i < ND; i++) if (a_val[4*i +: 4] != 4'h0) hi = i;
    ea = 4'hF; es = 7'h7F;
    if (w >= BLK) begin
      ea = ~(4'b0001 << d);
      if (a_en[d] && !(a_lz && d != 0 && d > hi)) es = SEG_TAB[a_val[4*d +: 4]];
    end
    ef = (pos == FRAME - 1);
    ek = ef && pv;
    check("outputs{an,sseg,fd,ack}", 32'({an, sseg, frame_done, load_ack}), 32'({ea, es, ef, ek}));
    if (tbl_on && w >= BLK) check("table_sseg", 32'(sseg), 32'(tbl_seg[d]));
    if (an != 4'hF) begin
      check("one_anode_low", 32'($countones(~an)), 32'd1);
      if (off_run == 0) check("no_adjacent_digits", 32'(an), 32'(last_lit));
      else              check("blank_gap", 32'(off_run >= BLK), 32'd1);
      off_run = 0; last_lit = an;
      if (first_lit < 0) first_lit = t;
    end else begin
      off_run++;
    end
    if (frame_done) fd_q.push_back(t);
    if (load_ack) ack_seen++;
    if (sseg != 7'h7F) seg_lit++;
    @(posedge clk);
    if (ek) begin a_val = p_val; a_en = p_en; a_lz = p_lz; pv = 1'b0; end
    if (ld) begin p_val = v; p_en = e; p_lz = lz; pv = 1'b1; end
    t++;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic align();
    while (t % FRAME != 0) idle();
  endtask

  initial begin
    vecs[0] = '{16'h12A0, 4'hF,    1'b0, {7'h79, 7'h24, 7'h08, 7'h40}};
    vecs[1] = '{16'h0005, 4'hF,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[2] = '{16'h0005, 4'hF,    1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};
    vecs[3] = '{16'h00F0, 4'hF,    1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40}};
    vecs[4] = '{16'h8081, 4'b1010, 1'b1, {7'h00, 7'h7F, 7'h00, 7'h7F}};
    vecs[5] = '{16'h0000, 4'hF,    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[6] = '{16'h3B0C, 4'hF,    1'b1, {7'h30, 7'h03, 7'h40, 7'h46}};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({an, sseg, frame_done, load_ack}), 32'({4'hF, 7'h7F, 1'b0, 1'b0}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Idle after reset: dark display, frame_done at 23 and 47, no load_ack.
    fd_q.delete(); ack_seen = 0; seg_lit = 0;
    repeat (2 * FRAME) idle();
    check("first_an_low_cycle", 32'(first_lit), 32'(BLK));
    check("idle_fd_count", 32'(fd_q.size()), 32'd2);
    foreach (fd_q[i]) check("idle_fd_cycle", 32'(fd_q[i]), 32'(FRAME - 1 + FRAME * i));
    check("idle_no_ack", 32'(ack_seen), 32'd0);
    check("idle_dark", 32'(seg_lit), 32'd0);

    // Table vectors: load at frame start, commit at frame end, check the following frame.
    for (int k = 0; k < 7; k++) begin
      align();
      ack_seen = 0;
      step(1'b1, vecs[k].val, vecs[k].en, vecs[k].lz);
      repeat (FRAME - 1) idle();
      check("table_ack_once", 32'(ack_seen), 32'd1);
      tbl_seg = vecs[k].seg; tbl_on = 1'b1;
      repeat (FRAME) idle();
      tbl_on = 1'b0;
    end

    // Two loads in one frame: one ack, latest value wins.
    align();
    ack_seen = 0;
    repeat (3) idle();
    step(1'b1, 16'h1111, 4'hF, 1'b0);
    repeat (6) idle();
    step(1'b1, 16'h2222, 4'hF, 1'b0);
    align();
    check("double_load_single_ack", 32'(ack_seen), 32'd1);
    tbl_seg = {4{7'h24}}; tbl_on = 1'b1;
    repeat (FRAME) idle();
    tbl_on = 1'b0;
    check("double_load_no_extra_ack", 32'(ack_seen), 32'd1);

    // Load on the frame_done cycle is held for the following frame.
    repeat (FRAME - 1) idle();
    ack_seen = 0;
    step(1'b1, 16'h5555, 4'hF, 1'b0);
    check("fd_cycle_load_not_acked", 32'(ack_seen), 32'd0);
    tbl_seg = {4{7'h24}}; tbl_on = 1'b1;
    repeat (FRAME) idle();
    check("fd_cycle_load_acked_next", 32'(ack_seen), 32'd1);
    tbl_seg = {4{7'h12}};
    repeat (FRAME) idle();
    tbl_on = 1'b0;

    // Asynchronous reset mid-SHOW of digit 2, with a load still pending.
    align();
    repeat (3) idle();
    step(1'b1, 16'hFFFF, 4'hF, 1'b0);
    repeat (2 * SLOT + BLK + 1 - 4) idle();
    @(negedge clk);
    check("pre_reset_digit2_lit", 32'(an), 32'(4'b1011));
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({an, sseg, frame_done, load_ack}), 32'({4'hF, 7'h7F, 1'b0, 1'b0}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    ack_seen = 0; seg_lit = 0;
    repeat (2 * FRAME) idle();
    check("reset_discards_pending", 32'(ack_seen), 32'd0);
    check("reset_clears_active", 32'(seg_lit), 32'd0);
    check("restart_first_an_low", 32'(first_lit), 32'(BLK));

    // Random loads over 10 frames against the model.
    for (int c = 0; c < 10 * FRAME; c++) begin
      step(1'($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
